// File: rtl/instr_fetch_unit_if.sv
// Handshake bundle around instr_fetch_unit: instruction-memory port, core-side
// valid/ready port and the redirect request. master = fetch unit, slave = memory/core.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, instruction, instr_pc, instr_valid,
        input  imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_pc, instr_valid,
        output imem_ack, imem_rdata, instr_ready, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetch PC, imem req/ack, small PC+word FIFO, redirect/flush.
// Define IFU_PERF_EN to add the fetch_count / drop_count performance counters.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    instr_fetch_unit_if.master     ifc
`ifdef IFU_PERF_EN
    ,
    output logic [31:0]            fetch_count,
    output logic [15:0]            drop_count
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [31:0]     fetch_pc, fetch_pc_nxt;
    logic [31:0]     pending_pc, pending_pc_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic            req_q, req_nxt;

    logic [31:0]     fifo_pc   [FIFO_DEPTH];
    logic [31:0]     fifo_data [FIFO_DEPTH];

    logic            acked, push, pop, discard;
    logic [31:0]     redirect_aligned;

    // Low address bits of a redirect target are meaningless for word fetches.
    assign redirect_aligned = ifc.redirect_pc & 32'hFFFF_FFFC;

    assign acked = req_q & ifc.imem_ack;
    assign push  = (state == REQ) & acked & ~ifc.redirect;
    assign pop   = (count != '0) & ifc.instr_ready;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        pending_pc_nxt = pending_pc;
        discard        = 1'b0;

        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (ifc.redirect) begin
                    discard = acked;
                    if (req_q && !ifc.imem_ack) begin
                        pending_pc_nxt = redirect_aligned;
                        state_nxt      = DROP;
                    end else begin
                        fetch_pc_nxt = redirect_aligned;
                    end
                end else if (push) begin
                    fetch_pc_nxt = fetch_pc + 32'd4;
                end
            end
            DROP: begin
                if (acked) begin
                    // The abandoned word is thrown away; a same-cycle redirect wins.
                    discard      = 1'b1;
                    fetch_pc_nxt = ifc.redirect ? redirect_aligned : pending_pc;
                    state_nxt    = REQ;
                end else if (ifc.redirect) begin
                    pending_pc_nxt = redirect_aligned;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (ifc.redirect) count_nxt = '0;
        else              count_nxt = count + CW'(push) - CW'(pop);

        req_nxt = (state_nxt == DROP) ||
                  ((state_nxt == REQ) && (count_nxt < CW'(FIFO_DEPTH)));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            req_q      <= 1'b0;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            pending_pc <= pending_pc_nxt;
            count      <= count_nxt;
            req_q      <= req_nxt;
            if (ifc.redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (pop)  rd_ptr <= rd_ptr + AW'(1);
                if (push) wr_ptr <= wr_ptr + AW'(1);
            end
        end
    end

    // NOTE: FIFO storage has no reset; outputs are masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]   <= fetch_pc;
            fifo_data[wr_ptr] <= ifc.imem_rdata;
        end
    end

    assign ifc.imem_req    = req_q;
    assign ifc.imem_addr   = fetch_pc;
    assign ifc.instr_valid = (count != '0);
    assign ifc.instruction = (count != '0) ? fifo_data[rd_ptr] : 32'h0;
    assign ifc.instr_pc    = (count != '0) ? fifo_pc[rd_ptr]   : 32'h0;

`ifdef IFU_PERF_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            drop_count  <= '0;
        end else begin
            if (push && (fetch_count != '1))   fetch_count <= fetch_count + 32'd1;
            if (discard && (drop_count != '1)) drop_count  <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a queue-based fetch model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_instr_fetch_unit;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
`ifdef IFU_PERF_EN
    logic [31:0] fetch_count;
    logic [15:0] drop_count;
`endif

    instr_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .ifc   (bus)
`ifdef IFU_PERF_EN
        ,
        .fetch_count (fetch_count),
        .drop_count  (drop_count)
`endif
    );

    // Memory returns a word derived from its address.
    assign bus.imem_rdata = bus.imem_addr ^ 32'hA5A5_0000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] data; } entry_t;
    entry_t      mq[$];
    bit          m_running = 0;
    bit          m_dropping = 0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_pending = 32'h0;
    int          m_fetches = 0;
    int          m_drops = 0;

    function automatic bit model_req();
        return m_running && (m_dropping || mq.size() < DEPTH);
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq.delete();
            m_running = 0; m_dropping = 0;
            m_pc = 32'h0; m_pending = 32'h0;
            m_fetches = 0; m_drops = 0;
        end else begin
            bit req, acked;
            req   = model_req();
            acked = req && bus.imem_ack;
            if (!m_running) begin
                m_running = 1;
            end else if (bus.redirect) begin
                mq.delete();
                if (acked) m_drops++;
                if (!m_dropping && req && !bus.imem_ack) begin
                    m_dropping = 1;
                    m_pending  = {bus.redirect_pc[31:2], 2'b00};
                end else if (m_dropping && !acked) begin
                    m_pending = {bus.redirect_pc[31:2], 2'b00};
                end else begin
                    m_dropping = 0;
                    m_pc = {bus.redirect_pc[31:2], 2'b00};
                end
            end else begin
                if (mq.size() != 0 && bus.instr_ready) void'(mq.pop_front());
                if (m_dropping) begin
                    if (acked) begin
                        m_dropping = 0;
                        m_pc = m_pending;
                        m_drops++;
                    end
                end else if (acked) begin
                    mq.push_back('{pc: m_pc, data: m_pc ^ 32'hA5A5_0000});
                    m_pc = m_pc + 32'd4;
                    m_fetches++;
                end
            end
        end
    end

    // Compare process: outputs are checked on the falling edge every cycle.
    always @(negedge clk) begin
        check("m_req",   {31'b0, bus.imem_req},    {31'b0, model_req()});
        check("m_addr",  bus.imem_addr,            m_pc);
        check("m_valid", {31'b0, bus.instr_valid}, {31'b0, mq.size() != 0});
        if (mq.size() != 0) begin
            check("m_pc",   bus.instr_pc,    mq[0].pc);
            check("m_inst", bus.instruction, mq[0].data);
        end else begin
            check("m_pc0",   bus.instr_pc,    32'h0);
            check("m_inst0", bus.instruction, 32'h0);
        end
`ifdef IFU_PERF_EN
        check("m_fcnt", fetch_count, m_fetches);
        check("m_dcnt", {16'h0, drop_count}, m_drops);
`endif
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_redirect(input logic [31:0] pc);
        bus.redirect = 1'b1;
        bus.redirect_pc = pc;
        tick();
        bus.redirect = 1'b0;
    endtask

    initial begin
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;

        // Reset state
        #2;
        check("rst_req",   {31'b0, bus.imem_req},    32'h0);
        check("rst_addr",  bus.imem_addr,            32'h0);
        check("rst_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("rst_inst",  bus.instruction,          32'h0);
        check("rst_ipc",   bus.instr_pc,             32'h0);
        tick(); tick();

        // Streaming: ack tied high, core always ready
        bus.imem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        reset = 1'b1;
        tick();
        check("s_req1",   {31'b0, bus.imem_req},    32'h1);
        check("s_addr0",  bus.imem_addr,            32'h0);
        check("s_valid0", {31'b0, bus.instr_valid}, 32'h0);
        tick();
        check("s_valid1", {31'b0, bus.instr_valid}, 32'h1);
        check("s_inst0",  bus.instruction,          32'hA5A5_0000);
        check("s_addr4",  bus.imem_addr,            32'h4);
        for (int i = 1; i < 5; i++) begin
            tick();
            check("s_seq", bus.instr_pc, 32'(i * 4));
        end
        check("s_inst10", bus.instruction, 32'hA5A5_0010);

        // Back-pressure: fill FIFO, fetch stalls at 8, then drains and resumes
        reset = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        tick();
        tick();
        check("bp_req0",  {31'b0, bus.imem_req}, 32'h0);
        check("bp_addr8", bus.imem_addr,         32'h8);
        check("bp_head0", bus.instr_pc,          32'h0);
        tick(); tick();
        check("bp_hold",  bus.imem_addr,         32'h8);
        bus.instr_ready = 1'b1;
        tick();
        check("bp_head4", bus.instr_pc,          32'h4);
        check("bp_req1",  {31'b0, bus.imem_req}, 32'h1);
        tick();
        check("bp_head8", bus.instr_pc,          32'h8);

        // Redirect with no outstanding request (FIFO full)
        bus.instr_ready = 1'b0;
        tick();
        check("r1_full", {31'b0, bus.imem_req}, 32'h0);
        pulse_redirect(32'h0000_1003);
        bus.instr_ready = 1'b1;
        check("r1_valid0", {31'b0, bus.instr_valid}, 32'h0);
        check("r1_addr",   bus.imem_addr,            32'h0000_1000);
        tick();
        check("r1_pc",     bus.instr_pc,             32'h0000_1000);

        // Redirect while a request to 0x10 is pending: DROP
        bus.instr_ready = 1'b0;
        tick(); tick();
        bus.imem_ack = 1'b0;
        pulse_redirect(32'h0000_0010);
        check("d_addr10", bus.imem_addr,         32'h10);
        check("d_req",    {31'b0, bus.imem_req}, 32'h1);
        pulse_redirect(32'h0000_0200);
        check("d_hold1",  bus.imem_addr,         32'h10);
        tick(); tick();
        check("d_hold3",  bus.imem_addr,         32'h10);
        check("d_valid",  {31'b0, bus.instr_valid}, 32'h0);
        bus.imem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        check("d_nodata", {31'b0, bus.instr_valid}, 32'h0);
        check("d_addr200", bus.imem_addr,           32'h200);
        tick();
        check("d_pc200",  bus.instr_pc,             32'h200);

        // Redirect coincident with ack, and PC wrap
        pulse_redirect(32'hFFFF_FFF8);
        check("w_valid0", {31'b0, bus.instr_valid}, 32'h0);
        check("w_addr",   bus.imem_addr,            32'hFFFF_FFF8);
        tick();
        check("w_pc0",    bus.instr_pc,             32'hFFFF_FFF8);
        check("w_inst0",  bus.instruction,          32'h5A5A_FFF8);
        tick();
        check("w_pc1",    bus.instr_pc,             32'hFFFF_FFFC);
        tick();
        check("w_pc2",    bus.instr_pc,             32'h0000_0000);
        check("w_inst2",  bus.instruction,          32'hA5A5_0000);

        // Asynchronous reset mid-request with a non-empty FIFO
        bus.imem_ack = 1'b0;
        bus.instr_ready = 1'b0;
        tick();
        check("ar_pre", {31'b0, bus.imem_req}, 32'h1);
        #1 reset = 1'b0;
        #1;
        check("ar_req",   {31'b0, bus.imem_req},    32'h0);
        check("ar_valid", {31'b0, bus.instr_valid}, 32'h0);
        check("ar_addr",  bus.imem_addr,            32'h0);
`ifdef IFU_PERF_EN
        check("ar_fcnt", fetch_count,           32'h0);
        check("ar_dcnt", {16'h0, drop_count},   32'h0);
`endif
        tick(); tick();
        reset = 1'b1;
        bus.imem_ack = 1'b1;
        bus.instr_ready = 1'b1;
        tick();
        check("ar_req1",  {31'b0, bus.imem_req}, 32'h1);
        check("ar_addr0", bus.imem_addr,         32'h0);
        tick();
        check("ar_pc0",   bus.instr_pc,          32'h0);
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
